// File: rtl/forward_hazard_unit_if.sv
// Operand-forwarding bus between the decode/execute boundary and forward_hazard_unit.
// The master drives producer/consumer info; the slave (the unit) returns selects and stats.
interface forward_hazard_unit_if #(
    parameter int unsigned REG_NUM_WIDTH = 5,
    parameter int unsigned DEPTH         = 2,
    parameter int unsigned READ_PORTS    = 2
);
    localparam int unsigned SEL_W = $clog2(DEPTH + 1);

    logic                                stall;
    logic                                flush;
    logic [REG_NUM_WIDTH-1:0]            wr_num;
    logic                                wr_en;
    logic                                wr_is_load;
    logic [READ_PORTS*REG_NUM_WIDTH-1:0] rd_num;
    logic [READ_PORTS-1:0]               rd_used;
    logic [READ_PORTS*SEL_W-1:0]         fwd_sel;
    logic                                load_use_stall;
    logic [15:0]                         fwd_count;
    logic [15:0]                         stall_count;

    modport master (
        output stall, flush, wr_num, wr_en, wr_is_load, rd_num, rd_used,
        input  fwd_sel, load_use_stall, fwd_count, stall_count
    );

    modport slave (
        input  stall, flush, wr_num, wr_en, wr_is_load, rd_num, rd_used,
        output fwd_sel, load_use_stall, fwd_count, stall_count
    );
endinterface

// File: rtl/forward_hazard_unit.sv
// Register-forwarding select and load-use hazard detection over the last DEPTH writers.
// Optional event counters are built only when FORWARD_STATS_EN is defined.
module forward_hazard_unit #(
    parameter int unsigned REG_NUM_WIDTH = 5,
    parameter int unsigned DEPTH         = 2,
    parameter int unsigned READ_PORTS    = 2,
    localparam int unsigned SEL_W        = $clog2(DEPTH + 1)
) (
    input logic                  clk,
    input logic                  rst_n,
    forward_hazard_unit_if.slave bus
);

    // Index k-1 holds stage k; stage 1 is combinational from the current producer.
    logic [DEPTH-1:0][REG_NUM_WIDTH-1:0] stage_num;
    logic [DEPTH-1:0]                    stage_valid;

    logic                                num1_nonzero;
    logic                                valid1;
    logic [READ_PORTS*SEL_W-1:0]         fwd_sel;
    logic                                load_use_stall;
    logic [REG_NUM_WIDTH-1:0]            rd_cur;
    logic [SEL_W-1:0]                    port_sel;

    assign num1_nonzero = |bus.wr_num;
    assign valid1       = bus.wr_en & ~bus.flush & rst_n & num1_nonzero;

    // is_load only matters while the producer is in stage 1, so it is not carried further.
    if (DEPTH > 1) begin : g_hist
        logic [DEPTH-1:1][REG_NUM_WIDTH-1:0] num_q;
        logic [DEPTH-1:1]                    valid_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                num_q   <= '0;
                valid_q <= '0;
            end else if (!bus.stall) begin
                num_q[1]   <= bus.wr_num;
                valid_q[1] <= valid1;
                for (int j = 2; j < int'(DEPTH); j++) begin
                    num_q[j]   <= num_q[j-1];
                    valid_q[j] <= valid_q[j-1];
                end
            end
        end

        assign stage_num   = {num_q, bus.wr_num};
        assign stage_valid = {valid_q, valid1};
    end else begin : g_no_hist
        assign stage_num   = bus.wr_num;
        assign stage_valid = valid1;
    end

    // Scan oldest to youngest so the youngest match overwrites the select.
    always_comb begin
        fwd_sel        = '0;
        load_use_stall = 1'b0;
        rd_cur         = '0;
        port_sel       = '0;
        for (int p = 0; p < int'(READ_PORTS); p++) begin
            rd_cur   = bus.rd_num[p*REG_NUM_WIDTH +: REG_NUM_WIDTH];
            port_sel = '0;
            for (int k = int'(DEPTH); k >= 1; k--) begin
                if (bus.rd_used[p] && stage_valid[k-1] && (stage_num[k-1] == rd_cur) &&
                    (rd_cur != '0)) begin
                    if (k == 1 && bus.wr_is_load) begin
                        load_use_stall = 1'b1;
                    end else begin
                        port_sel = SEL_W'(k);
                    end
                end
            end
            fwd_sel[p*SEL_W +: SEL_W] = port_sel;
        end
    end

    assign bus.fwd_sel        = fwd_sel;
    assign bus.load_use_stall = load_use_stall;

`ifdef FORWARD_STATS_EN
    logic [15:0] fwd_count_q;
    logic [15:0] stall_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_count_q   <= '0;
            stall_count_q <= '0;
        end else begin
            if ((|fwd_sel) && !bus.stall && (fwd_count_q != 16'hFFFF)) begin
                fwd_count_q <= fwd_count_q + 16'd1;
            end
            if (load_use_stall && (stall_count_q != 16'hFFFF)) begin
                stall_count_q <= stall_count_q + 16'd1;
            end
        end
    end

    assign bus.fwd_count   = fwd_count_q;
    assign bus.stall_count = stall_count_q;
`else
    assign bus.fwd_count   = '0;
    assign bus.stall_count = '0;
`endif

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed-vector bench for forward_hazard_unit at default parameters (DEPTH=2, 2 ports).
module tb_forward_hazard_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    forward_hazard_unit_if #(
        .REG_NUM_WIDTH(5),
        .DEPTH(2),
        .READ_PORTS(2)
    ) bus ();

    forward_hazard_unit #(
        .REG_NUM_WIDTH(5),
        .DEPTH(2),
        .READ_PORTS(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then wait to the falling edge for sampling.
    task automatic drive(input logic [4:0] wn, input logic we, input logic ld, input logic fl,
                         input logic st, input logic [4:0] r0, input logic [4:0] r1,
                         input logic [1:0] used);
        bus.wr_num     = wn;
        bus.wr_en      = we;
        bus.wr_is_load = ld;
        bus.flush      = fl;
        bus.stall      = st;
        bus.rd_num     = {r1, r0};
        bus.rd_used    = used;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;

        // In reset a live write/read pair must not forward.
        drive(5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 5'd0, 2'b01);
        check("rst_sel", 32'(bus.fwd_sel), 32'h0);
        check("rst_lus", 32'(bus.load_use_stall), 32'h0);
        check("rst_fcnt", 32'(bus.fwd_count), 32'h0);
        check("rst_scnt", 32'(bus.stall_count), 32'h0);
        tick();
        rst_n = 1'b1;

        // Basic forwarding: stage 1, then stage 2, then gone.
        drive(5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 5'd0, 2'b01);
        check("basic_s1", 32'(bus.fwd_sel[1:0]), 32'd1);
        tick();
        drive(5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd0, 2'b01);
        check("basic_s2", 32'(bus.fwd_sel[1:0]), 32'd2);
        tick();
        drive(5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd0, 2'b01);
        check("basic_none", 32'(bus.fwd_sel[1:0]), 32'd0);
        tick();

        // Youngest wins when both stages hold x7.
        drive(5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
        tick();
        drive(5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd7, 2'b10);
        check("prio_p1", 32'(bus.fwd_sel), 32'h4);
        tick();
        // x0 never forwards nor stalls, even as a load.
        drive(5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 2'b11);
        check("x0_sel", 32'(bus.fwd_sel), 32'h0);
        check("x0_lus", 32'(bus.load_use_stall), 32'h0);
        tick();
        // Both ports hit the same stage.
        drive(5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 5'd8, 2'b11);
        check("both_ports", 32'(bus.fwd_sel), 32'h5);
        tick();

        // Load-use: stall with select 0, then forward from stage 2.
        drive(5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 5'd0, 2'b01);
        check("lu_stall", 32'(bus.load_use_stall), 32'h1);
        check("lu_sel", 32'(bus.fwd_sel[1:0]), 32'd0);
        tick();
        drive(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd0, 2'b01);
        check("lu_next_stall", 32'(bus.load_use_stall), 32'h0);
        check("lu_next_sel", 32'(bus.fwd_sel[1:0]), 32'd2);
        tick();

        // Stage-1 load over stage-2 ALU result: select falls to 2 with a stall.
        drive(5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
        tick();
        drive(5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 5'd0, 2'b01);
        check("lu_fall_sel", 32'(bus.fwd_sel[1:0]), 32'd2);
        check("lu_fall_stall", 32'(bus.load_use_stall), 32'h1);
        tick();

        // Stall holds x9 in stage 2.
        drive(5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd0, 2'b01);
            check("stall_hold", 32'(bus.fwd_sel[1:0]), 32'd2);
            tick();
        end
        drive(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9, 5'd0, 2'b01);
        check("stall_after", 32'(bus.fwd_sel[1:0]), 32'd2);
        tick();
        drive(5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
        tick();
        drive(5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
        tick();
        // Flush of x9 with x9 in stage 2: stage 2 still serves, stage 1 ignored.
        drive(5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9, 5'd0, 2'b01);
        check("flush_s1", 32'(bus.fwd_sel[1:0]), 32'd2);
        tick();
        drive(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9, 5'd0, 2'b01);
        check("flush_capture", 32'(bus.fwd_sel[1:0]), 32'd0);
        tick();

        // Stall and flush together: stage 2 keeps x10, stage 1 x11 is invalid.
        drive(5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
        tick();
        drive(5'd11, 1'b1, 1'b0, 1'b1, 1'b1, 5'd11, 5'd10, 2'b11);
        check("stfl_sel", 32'(bus.fwd_sel), 32'h8);
        tick();
        drive(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd11, 5'd10, 2'b11);
        check("stfl_hold", 32'(bus.fwd_sel), 32'h8);
        tick();

        // Asynchronous reset with x4 in stage 2.
        drive(5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
        tick();
        drive(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4, 5'd0, 2'b01);
        check("pre_rst", 32'(bus.fwd_sel[1:0]), 32'd2);
        #1 rst_n = 1'b0;
        #1 check("async_rst", 32'(bus.fwd_sel[1:0]), 32'd0);
        tick();
        rst_n = 1'b1;
        drive(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4, 5'd0, 2'b01);
        check("post_rst", 32'(bus.fwd_sel[1:0]), 32'd0);
        tick();

        // Counter sequence: 2 load-use stalls and 3 forwarding edges.
        drive(5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 5'd0, 2'b01);
        tick();
        drive(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd0, 2'b01);
        tick();
        drive(5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 5'd0, 2'b01);
        tick();
        drive(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd0, 2'b01);
        tick();
        drive(5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 5'd6, 5'd0, 2'b01);
        tick();
        drive(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
`ifdef FORWARD_STATS_EN
        check("fwd_count", 32'(bus.fwd_count), 32'd3);
        check("stall_count", 32'(bus.stall_count), 32'd2);
        tick();
        // Continuous load-use on x3 saturates both counters.
        for (int i = 0; i < 70000; i++) begin
            drive(5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 5'd0, 2'b01);
            tick();
        end
        drive(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
        check("stall_sat", 32'(bus.stall_count), 32'h0000FFFF);
        check("fwd_sat", 32'(bus.fwd_count), 32'h0000FFFF);
`else
        check("fwd_count_off", 32'(bus.fwd_count), 32'd0);
        check("stall_count_off", 32'(bus.stall_count), 32'd0);
`endif
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
